// File: rtl/switch_ram.sv
// Switch-driven RAM: debounced Load / Clear / ClearAll buttons write, zero or sweep a
// 2^ADDR_W x DATA_W store; LED shows the word at A one clock later.
module switch_ram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int DB_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] D,
    input  logic [ADDR_W-1:0] A,
    input  logic              Load,
    input  logic              Clear,
    input  logic              ClearAll,
    output logic [DATA_W-1:0] LED,
    output logic [ADDR_W-1:0] Ao,
    output logic              Busy,
    output logic              Ack
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [ADDR_W:0]   PTR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    // Button index 0 = Load, 1 = Clear, 2 = ClearAll.
    logic [2:0]       btn_raw;
    logic             sync1_q [3];
    logic             sync2_q [3];
    logic             lvl_q   [3];
    logic             lvl_d   [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic             cmd     [3];

    assign btn_raw = {ClearAll, Clear, Load};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            // Level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                lvl_d[gi] = lvl_q[gi];
                if (sync2_q[gi] == lvl_q[gi]) begin
                    cnt_d[gi] = '0;
                end else if (cnt_q[gi] == CNT_LAST) begin
                    cnt_d[gi] = '0;
                    lvl_d[gi] = ~lvl_q[gi];
                end else begin
                    cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
                end
            end

            // Command fires in the same cycle the debounced level is about to rise.
            assign cmd[gi] = lvl_d[gi] & ~lvl_q[gi];

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    sync1_q[gi] <= 1'b0;
                    sync2_q[gi] <= 1'b0;
                    cnt_q[gi]   <= '0;
                    lvl_q[gi]   <= 1'b0;
                end else begin
                    sync1_q[gi] <= btn_raw[gi];
                    sync2_q[gi] <= sync1_q[gi];
                    cnt_q[gi]   <= cnt_d[gi];
                    lvl_q[gi]   <= lvl_d[gi];
                end
            end
        end
    endgenerate

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              ack_q, ack_d;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = 1'b0;
        we      = 1'b0;
        waddr   = A;
        wdata   = D;
        case (state_q)
            IDLE: begin
                if (cmd[2]) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else if (cmd[0] && !lvl_d[1]) begin
                    we    = 1'b1;
                    ack_d = 1'b1;
                end else if (cmd[1] && !lvl_d[0]) begin
                    we    = 1'b1;
                    wdata = '0;
                    ack_d = 1'b1;
                end
            end
            SWEEP: begin
                we    = 1'b1;
                waddr = ptr_q[ADDR_W-1:0];
                wdata = '0;
                ptr_d = ptr_q + (ADDR_W + 1)'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
        end
    end

    // Storage has no reset; the post-reset sweep is what zeroes it.
    logic [DATA_W-1:0] store_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (we && !Reset) begin
            store_q[waddr] <= wdata;
        end
    end

    logic [DATA_W-1:0] led_q;
    logic [ADDR_W-1:0] ao_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            led_q <= '0;
            ao_q  <= '0;
        end else begin
            led_q <= store_q[A];
            ao_q  <= A;
        end
    end

    assign LED  = led_q;
    assign Ao   = ao_q;
    assign Busy = (state_q == SWEEP);
    assign Ack  = ack_q;

endmodule

// File: tb/tb_switch_ram.sv
// Directed bench for switch_ram: reset sweep, load timing, table of button
// transactions, ClearAll sweep with ignored Load, and reset mid-sweep.
module tb_switch_ram;

    logic       Clk = 1'b0;
    logic       Reset, Load, Clear, ClearAll;
    logic [7:0] D, LED;
    logic [4:0] A, Ao;
    logic       Busy, Ack;

    switch_ram #(.DATA_W(8), .ADDR_W(5), .DB_CYCLES(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .D        (D),
        .A        (A),
        .Load     (Load),
        .Clear    (Clear),
        .ClearAll (ClearAll),
        .LED      (LED),
        .Ao       (Ao),
        .Busy     (Busy),
        .Ack      (Ack)
    );

    always #5 Clk = ~Clk;

    int tests    = 0;
    int fails    = 0;
    int ack_seen = 0;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        logic       ld;
        logic       clr;
        logic       bounce;
        int         exp_acks;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge Clk);
        #1;
        if (Ack) ack_seen++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts samples with Busy high, starting at the current sample.
    task automatic wait_busy_fall(output int n);
        n = 0;
        for (int k = 0; k < 100 && Busy; k++) begin
            n++;
            step();
        end
    endtask

    task automatic wait_busy_rise(output int n);
        n = 0;
        while (!Busy && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            A = 5'(i);
            step();
            check($sformatf("%s word %0d", tag, i), {24'd0, LED}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bcnt;
        vecs[0] = '{a: 5'd10, d: 8'h3C, ld: 1'b1, clr: 1'b0, bounce: 1'b1, exp_acks: 1, exp_led: 8'h3C};
        vecs[1] = '{a: 5'd7,  d: 8'hFF, ld: 1'b1, clr: 1'b1, bounce: 1'b0, exp_acks: 0, exp_led: 8'hA5};
        vecs[2] = '{a: 5'd7,  d: 8'h11, ld: 1'b0, clr: 1'b1, bounce: 1'b0, exp_acks: 1, exp_led: 8'h00};
        vecs[3] = '{a: 5'd3,  d: 8'h81, ld: 1'b1, clr: 1'b0, bounce: 1'b0, exp_acks: 1, exp_led: 8'h81};
        vecs[4] = '{a: 5'd31, d: 8'h7E, ld: 1'b1, clr: 1'b0, bounce: 1'b0, exp_acks: 1, exp_led: 8'h7E};
        vecs[5] = '{a: 5'd0,  d: 8'hFF, ld: 1'b1, clr: 1'b0, bounce: 1'b1, exp_acks: 1, exp_led: 8'hFF};

        // Reset for 3 cycles, then the power-up sweep.
        Reset = 1'b1; Load = 1'b0; Clear = 1'b0; ClearAll = 1'b0; D = 8'h00; A = 5'd5;
        repeat (3) step();
        check("reset Busy", {31'd0, Busy}, 32'd1);
        check("reset LED", {24'd0, LED}, 32'd0);
        check("reset Ao", {27'd0, Ao}, 32'd0);
        check("reset Ack", {31'd0, Ack}, 32'd0);
        Reset = 1'b0;
        ack_seen = 0;
        wait_busy_fall(n);
        check("reset sweep length", n, 32'd32);
        check("reset sweep Ack at Busy fall", {31'd0, Ack}, 32'd1);
        repeat (5) step();
        check("reset sweep Ack count", ack_seen, 32'd1);
        $display("[TB] reset sweep: busy %0d cycles, acks %0d", n, ack_seen);
        read_all_zero("post-reset");
        check("Ao follows A", {27'd0, Ao}, 32'd31);

        // Clean Load: write 6 clocks after the raw edge, Ack the cycle after, LED one later.
        A = 5'd7; D = 8'hA5; ack_seen = 0;
        step();
        Load = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("load Ack t%0d", i), {31'd0, Ack}, (i == 6) ? 32'd1 : 32'd0);
            check($sformatf("load LED t%0d", i), {24'd0, LED}, (i >= 7) ? 32'hA5 : 32'h00);
        end
        repeat (2) step();
        Load = 1'b0;
        repeat (10) step();
        check("load Ack count", ack_seen, 32'd1);
        check("load Busy idle", {31'd0, Busy}, 32'd0);
        $display("[TB] load a=7 d=a5 led=%h acks=%0d", LED, ack_seen);

        // Table of button transactions.
        for (int v = 0; v < 6; v++) begin
            A = vecs[v].a; D = vecs[v].d; ack_seen = 0;
            if (vecs[v].bounce) begin
                for (int b = 0; b < 3; b++) begin
                    Load = 1'b1; repeat (3) step();
                    Load = 1'b0; repeat (3) step();
                end
            end
            Load = vecs[v].ld; Clear = vecs[v].clr;
            repeat (10) step();
            Load = 1'b0; Clear = 1'b0;
            repeat (10) step();
            check($sformatf("vec%0d acks", v), ack_seen, vecs[v].exp_acks);
            check($sformatf("vec%0d LED", v), {24'd0, LED}, {24'd0, vecs[v].exp_led});
            $display("[TB] vec %0d a=%0d d=%h ld=%b clr=%b bounce=%b led=%h acks=%0d",
                     v, vecs[v].a, vecs[v].d, vecs[v].ld, vecs[v].clr, vecs[v].bounce, LED, ack_seen);
        end

        // ClearAll sweep with a Load arriving while Busy.
        A = 5'd3; D = 8'h55; ack_seen = 0;
        ClearAll = 1'b1;
        wait_busy_rise(n);
        check("clearall latency", n, 32'd6);
        ClearAll = 1'b0;
        Load = 1'b1;
        bcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (Busy) bcnt++;
            step();
        end
        Load = 1'b0;
        wait_busy_fall(n);
        bcnt += n;
        check("clearall sweep length", bcnt, 32'd32);
        check("clearall Ack at Busy fall", {31'd0, Ack}, 32'd1);
        repeat (10) step();
        check("clearall Ack count", ack_seen, 32'd1);
        $display("[TB] clearall sweep: busy %0d cycles, acks %0d", bcnt, ack_seen);
        read_all_zero("post-clearall");

        // Reset mid-sweep, with Load held through the release.
        ClearAll = 1'b1;
        wait_busy_rise(n);
        check("mid-sweep Busy rise", {31'd0, Busy}, 32'd1);
        ClearAll = 1'b0;
        repeat (10) step();
        A = 5'd5; D = 8'h55; Load = 1'b1; Reset = 1'b1;
        repeat (2) step();
        check("mid-sweep reset Busy", {31'd0, Busy}, 32'd1);
        check("mid-sweep reset Ack", {31'd0, Ack}, 32'd0);
        Reset = 1'b0;
        ack_seen = 0;
        wait_busy_fall(n);
        check("mid-sweep restart length", n, 32'd32);
        check("mid-sweep Ack at Busy fall", {31'd0, Ack}, 32'd1);
        Load = 1'b0;
        repeat (10) step();
        check("mid-sweep Ack count", ack_seen, 32'd1);
        A = 5'd5;
        step();
        check("held Load discarded", {24'd0, LED}, 32'd0);
        $display("[TB] reset mid-sweep: busy %0d cycles, acks %0d, word5=%h", n, ack_seen, LED);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
